// File: rtl/percep_pkg.sv
// Shared definitions for the perceptron operand path: fp width, default
// channel/stage counts and the packed channel vector type.
package percep_pkg;

    localparam int DEF_FP_WIDTH = 16;
    localparam int DEF_NCH      = 1;
    localparam int DEF_DEPTH    = 2;

    // One packed x or w vector at the default channel count.
    typedef logic [DEF_NCH*DEF_FP_WIDTH-1:0] chan_vec_t;

    // Width of a counter that must reach depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/percep_pipreg_stage.sv
// One elastic pipeline stage: a valid bit plus the x/w operand registers,
// with flush > stall > load priority below the synchronous reset.
module percep_pipreg_stage
    import percep_pkg::*;
#(
    parameter int W = DEF_FP_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         flush,
    input  logic         stall,
    input  logic         vld_in,
    input  logic [W-1:0] x_d,
    input  logic [W-1:0] w_d,
    output logic         vld,
    output logic [W-1:0] x_q,
    output logic [W-1:0] w_q
);

    // NOTE: the operand registers are reset too, so an empty pipe presents zeros
    // on its outputs straight after reset instead of stale power-up contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= 1'b0;
            x_q <= '0;
            w_q <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (!stall && load) begin
            vld <= vld_in;
            // Bubbles only clear the valid; the last real word stays visible.
            if (vld_in) begin
                x_q <= x_d;
                w_q <= w_d;
            end
        end
    end

endmodule

// File: rtl/percep_pipreg_xw_elastic.sv
// DEPTH-stage elastic x/w operand register between operand fetch and the MAC
// array: bubble-collapsing ready/valid chain, global stall and flush.
module percep_pipreg_xw_elastic
    import percep_pkg::*;
#(
    parameter int FP_WIDTH = DEF_FP_WIDTH,
    parameter int NCH      = DEF_NCH,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NCH*FP_WIDTH-1:0]      x_in,
    input  logic [NCH*FP_WIDTH-1:0]      w_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NCH*FP_WIDTH-1:0]      x_out_pip,
    output logic [NCH*FP_WIDTH-1:0]      w_out_pip,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int W     = NCH * FP_WIDTH;
    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy;
    logic [W-1:0]     xd [DEPTH];
    logic [W-1:0]     wd [DEPTH];
    logic             acc;
    logic             push;
    logic             pop;

    // A stage is ready when it, or any stage between it and the output, is
    // empty, or the consumer takes the final word this cycle.
    // NOTE: acc is a blocking temporary walked from the output back toward
    // the input; rdy is fully assigned first so no latch can form.
    always_comb begin
        rdy = '0;
        acc = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc    = acc | ~vld[k];
            rdy[k] = acc;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            percep_pipreg_stage #(.W(W)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (rdy[k]),
                .flush  (flush),
                .stall  (stall),
                .vld_in (in_valid),
                .x_d    (x_in),
                .w_d    (w_in),
                .vld    (vld[k]),
                .x_q    (xd[k]),
                .w_q    (wd[k])
            );
        end else begin : g_body
            percep_pipreg_stage #(.W(W)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (rdy[k]),
                .flush  (flush),
                .stall  (stall),
                .vld_in (vld[k-1]),
                .x_d    (xd[k-1]),
                .w_d    (wd[k-1]),
                .vld    (vld[k]),
                .x_q    (xd[k]),
                .w_q    (wd[k])
            );
        end
    end

    assign in_ready  = rdy[0] & ~stall & ~flush;
    assign out_valid = vld[DEPTH-1] & ~stall;
    assign x_out_pip = xd[DEPTH-1];
    assign w_out_pip = wd[DEPTH-1];

    // Internal moves keep the word count; only entry and exit change it.
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            occupancy <= '0;
        end else if (!stall) begin
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule
